// File: rtl/ahb_slave_arbiter.sv
// Per-slave AHB arbiter: round-robin grant of one slave among CHANNEL_NUM masters,
// burst-length ownership hold and data-phase tracking. Optional feature: AHB_ARB_LOCK_EN.
module ahb_slave_arbiter #(
    parameter int CHANNEL_NUM = 2,
    parameter int ID_W        = $clog2(CHANNEL_NUM)
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [CHANNEL_NUM-1:0]   hreq,
    input  logic [CHANNEL_NUM*2-1:0] htrans_in,
    input  logic [CHANNEL_NUM*3-1:0] hburst_in,
    input  logic [CHANNEL_NUM-1:0]   hmastlock_in,
    input  logic                     hready_in,
    output logic [CHANNEL_NUM-1:0]   addr_sel,
    output logic [CHANNEL_NUM-1:0]   data_sel,
    output logic [ID_W-1:0]          owner_id
);

    localparam logic [1:0] TRANS_IDLE   = 2'd0;
    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;

    localparam logic [2:0] BURST_SINGLE = 3'd0;
    localparam logic [2:0] BURST_WRAP4  = 3'd2;
    localparam logic [2:0] BURST_INCR4  = 3'd3;
    localparam logic [2:0] BURST_WRAP8  = 3'd4;
    localparam logic [2:0] BURST_INCR8  = 3'd5;
    localparam logic [2:0] BURST_WRAP16 = 3'd6;
    localparam logic [2:0] BURST_INCR16 = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_OWN
    } state_t;

    state_t                 state_reg, state_next;
    logic [CHANNEL_NUM-1:0] addr_sel_reg, addr_sel_next;
    logic [CHANNEL_NUM-1:0] data_sel_reg, data_sel_next;
    logic [ID_W-1:0]        owner_id_reg, owner_id_next;
    logic [ID_W-1:0]        ptr_reg, ptr_next;
    logic [3:0]             beat_cnt_reg, beat_cnt_next;

    logic [1:0]             trans_arr [CHANNEL_NUM];
    logic [2:0]             burst_arr [CHANNEL_NUM];

    logic                   owner_req;
    logic [1:0]             owner_trans;
    logic [2:0]             owner_burst;
    logic                   burst_end;
    logic                   owner_rp;
    logic                   rearb;
    logic                   win_found;
    logic [ID_W-1:0]        win_id;

    generate
        for (genvar gi = 0; gi < CHANNEL_NUM; gi++) begin : g_unpack
            assign trans_arr[gi] = htrans_in[gi*2 +: 2];
            assign burst_arr[gi] = hburst_in[gi*3 +: 3];
        end
    endgenerate

    // Remaining beats after the NONSEQ; undefined-length INCR loads 0 and never ends by count
    function automatic logic [3:0] burst_remaining(input logic [2:0] burst);
        case (burst)
            BURST_WRAP4,  BURST_INCR4:  return 4'd3;
            BURST_WRAP8,  BURST_INCR8:  return 4'd7;
            BURST_WRAP16, BURST_INCR16: return 4'd15;
            default:                    return 4'd0;
        endcase
    endfunction

    assign owner_req   = hreq[owner_id_reg];
    assign owner_trans = trans_arr[owner_id_reg];
    assign owner_burst = burst_arr[owner_id_reg];

    assign burst_end = (owner_trans == TRANS_IDLE)
                    || (owner_trans == TRANS_NONSEQ && owner_burst == BURST_SINGLE)
                    || (owner_trans == TRANS_SEQ && beat_cnt_reg == 4'd1);

`ifdef AHB_ARB_LOCK_EN
    logic owner_lock;
    assign owner_lock = hmastlock_in[owner_id_reg];
    // A locked owner can only lose the slave by dropping its request
    assign owner_rp   = !owner_req || (!owner_lock && burst_end);
`else
    logic lock_unused;
    assign lock_unused = ^hmastlock_in;
    assign owner_rp    = !owner_req || burst_end;
`endif

    assign rearb = (state_reg == ST_IDLE) || owner_rp;

    // Circular scan starting one past the last granted index
    always_comb begin
        int              idx;
        logic [ID_W-1:0] idx_w;
        idx       = 0;
        idx_w     = '0;
        win_found = 1'b0;
        win_id    = ptr_reg;
        for (int k = 1; k <= CHANNEL_NUM; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= CHANNEL_NUM) begin
                idx = idx - CHANNEL_NUM;
            end
            idx_w = ID_W'(idx);
            if (!win_found && hreq[idx_w]) begin
                win_found = 1'b1;
                win_id    = idx_w;
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_sel_next = addr_sel_reg;
        data_sel_next = data_sel_reg;
        owner_id_next = owner_id_reg;
        ptr_next      = ptr_reg;
        beat_cnt_next = beat_cnt_reg;

        if (hready_in) begin
            if (state_reg == ST_OWN && owner_req && owner_trans[1]) begin
                data_sel_next = addr_sel_reg;
            end else begin
                data_sel_next = '0;
            end

            if (state_reg == ST_OWN && owner_req) begin
                if (owner_trans == TRANS_NONSEQ) begin
                    beat_cnt_next = burst_remaining(owner_burst);
                end else if (owner_trans == TRANS_SEQ && beat_cnt_reg != 4'd0) begin
                    beat_cnt_next = beat_cnt_reg - 4'd1;
                end
            end

            if (rearb) begin
                if (win_found) begin
                    state_next            = ST_OWN;
                    addr_sel_next         = '0;
                    addr_sel_next[win_id] = 1'b1;
                    owner_id_next         = win_id;
                    ptr_next              = win_id;
                end else begin
                    state_next    = ST_IDLE;
                    addr_sel_next = '0;
                    owner_id_next = '0;
                end
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg    <= ST_IDLE;
            addr_sel_reg <= '0;
            data_sel_reg <= '0;
            owner_id_reg <= '0;
            ptr_reg      <= ID_W'(CHANNEL_NUM - 1);
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            addr_sel_reg <= addr_sel_next;
            data_sel_reg <= data_sel_next;
            owner_id_reg <= owner_id_next;
            ptr_reg      <= ptr_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    assign addr_sel = addr_sel_reg;
    assign data_sel = data_sel_reg;
    assign owner_id = owner_id_reg;

endmodule

// File: tb/tb_ahb_slave_arbiter.sv
// Directed-vector bench for ahb_slave_arbiter with two masters; expectations are hand-derived.
module tb_ahb_slave_arbiter;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NS     = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_INCR8  = 3'd5;

`ifdef AHB_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic       HCLK;
    logic       HRESETn;
    logic [1:0] hreq;
    logic [3:0] htrans_in;
    logic [5:0] hburst_in;
    logic [1:0] hmastlock_in;
    logic       hready_in;
    logic [1:0] addr_sel;
    logic [1:0] data_sel;
    logic [0:0] owner_id;

    int checks   = 0;
    int failures = 0;

    ahb_slave_arbiter #(
        .CHANNEL_NUM (2)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .hreq         (hreq),
        .htrans_in    (htrans_in),
        .hburst_in    (hburst_in),
        .hmastlock_in (hmastlock_in),
        .hready_in    (hready_in),
        .addr_sel     (addr_sel),
        .data_sel     (data_sel),
        .owner_id     (owner_id)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] t0, input logic [2:0] b0,
                         input logic [1:0] t1, input logic [2:0] b1);
        hreq      = req;
        htrans_in = {t1, t0};
        hburst_in = {b1, b0};
    endtask

    task automatic check_sel(input string tag, input logic [1:0] exp_addr, input logic [1:0] exp_data);
        check_eq({tag, ".addr_sel"}, 32'(addr_sel), 32'(exp_addr));
        check_eq({tag, ".data_sel"}, 32'(data_sel), 32'(exp_data));
    endtask

    task automatic apply_reset(input string tag);
        HRESETn      = 1'b0;
        hmastlock_in = 2'b00;
        hready_in    = 1'b1;
        drive(2'b00, T_IDLE, B_SINGLE, T_IDLE, B_SINGLE);
        tick();
        tick();
        check_sel({tag, ".rst"}, 2'b00, 2'b00);
        check_eq({tag, ".rst.owner_id"}, 32'(owner_id), 32'd0);
        #2 HRESETn = 1'b1;
    endtask

    initial begin
        HRESETn      = 1'b0;
        hready_in    = 1'b1;
        hmastlock_in = 2'b00;
        drive(2'b00, T_IDLE, B_SINGLE, T_IDLE, B_SINGLE);

        // Single request: grant next cycle, data phase one cycle later
        apply_reset("t1");
        drive(2'b01, T_NS, B_SINGLE, T_IDLE, B_SINGLE);
        tick(); check_sel("t1.grant", 2'b01, 2'b00);
        check_eq("t1.grant.owner_id", 32'(owner_id), 32'd0);
        tick(); check_sel("t1.accept", 2'b01, 2'b01);
        drive(2'b00, T_IDLE, B_SINGLE, T_IDLE, B_SINGLE);
        tick(); check_sel("t1.release", 2'b00, 2'b00);

        // Both request from reset: M0 first, then alternating
        apply_reset("t2");
        drive(2'b11, T_NS, B_SINGLE, T_NS, B_SINGLE);
        tick(); check_sel("t2.g0", 2'b01, 2'b00);
        tick(); check_sel("t2.g1", 2'b10, 2'b01);
        check_eq("t2.g1.owner_id", 32'(owner_id), 32'd1);
        tick(); check_sel("t2.g2", 2'b01, 2'b10);
        tick(); check_sel("t2.g3", 2'b10, 2'b01);

        // INCR4 held for four accepted beats against a competing M1
        apply_reset("t3");
        drive(2'b11, T_NS, B_INCR4, T_NS, B_SINGLE);
        tick(); check_sel("t3.grant", 2'b01, 2'b00);
        tick(); check_sel("t3.beat1", 2'b01, 2'b01);
        drive(2'b11, T_SEQ, B_INCR4, T_NS, B_SINGLE);
        tick(); check_sel("t3.beat2", 2'b01, 2'b01);
        tick(); check_sel("t3.beat3", 2'b01, 2'b01);
        tick(); check_sel("t3.beat4", 2'b10, 2'b01);
        check_eq("t3.beat4.owner_id", 32'(owner_id), 32'd1);
        drive(2'b10, T_IDLE, B_SINGLE, T_NS, B_SINGLE);
        tick(); check_sel("t3.m1", 2'b10, 2'b10);

        // INCR4 with three wait states on beat 2
        apply_reset("t4");
        drive(2'b11, T_NS, B_INCR4, T_NS, B_SINGLE);
        tick(); check_sel("t4.grant", 2'b01, 2'b00);
        tick(); check_sel("t4.beat1", 2'b01, 2'b01);
        drive(2'b11, T_SEQ, B_INCR4, T_NS, B_SINGLE);
        hready_in = 1'b0;
        for (int w = 0; w < 3; w++) begin
            tick(); check_sel($sformatf("t4.wait%0d", w), 2'b01, 2'b01);
        end
        hready_in = 1'b1;
        tick(); check_sel("t4.beat2", 2'b01, 2'b01);
        tick(); check_sel("t4.beat3", 2'b01, 2'b01);
        tick(); check_sel("t4.beat4", 2'b10, 2'b01);

        // Locked SINGLEs: held only when the lock feature is built in
        apply_reset("t5");
        hmastlock_in = 2'b01;
        drive(2'b11, T_NS, B_SINGLE, T_NS, B_SINGLE);
        tick(); check_sel("t5.grant", 2'b01, 2'b00);
        tick(); check_eq("t5.s1.addr_sel", 32'(addr_sel), LOCK_ON ? 32'd1 : 32'd2);
        tick(); check_eq("t5.s2.addr_sel", 32'(addr_sel), 32'd1);
        tick(); check_eq("t5.s3.addr_sel", 32'(addr_sel), LOCK_ON ? 32'd1 : 32'd2);
        hmastlock_in = 2'b00;
        drive(2'b10, T_IDLE, B_SINGLE, T_NS, B_SINGLE);
        tick(); check_eq("t5.unlock.addr_sel", 32'(addr_sel), 32'd2);

        // Asynchronous reset during beat 3 of INCR8, then pointer restored
        apply_reset("t6");
        drive(2'b11, T_NS, B_INCR8, T_NS, B_SINGLE);
        tick(); check_sel("t6.grant", 2'b01, 2'b00);
        tick(); check_sel("t6.beat1", 2'b01, 2'b01);
        drive(2'b11, T_SEQ, B_INCR8, T_NS, B_SINGLE);
        tick(); check_sel("t6.beat2", 2'b01, 2'b01);
        #2 HRESETn = 1'b0;
        #1 check_sel("t6.async", 2'b00, 2'b00);
        check_eq("t6.async.owner_id", 32'(owner_id), 32'd0);
        drive(2'b10, T_IDLE, B_SINGLE, T_NS, B_SINGLE);
        tick(); check_sel("t6.held", 2'b00, 2'b00);
        #2 HRESETn = 1'b1;
        tick(); check_sel("t6.regrant", 2'b10, 2'b00);
        check_eq("t6.regrant.owner_id", 32'(owner_id), 32'd1);
        tick(); check_sel("t6.data", 2'b10, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb_slave_arbiter.md
# ahb_slave_arbiter

Per-slave AHB arbiter that owns the one-hot select of the slave-side payload mux (address/control path) and of the return data-phase mux. It sits between the per-master address decoders and the slave port of the bus matrix. It shares one slave among CHANNEL_NUM masters with round-robin priority, holds ownership for the length of a defined-length burst, and tracks the data phase so that write data and the response return to the right master.

## Interface
- CHANNEL_NUM, 2: number of masters competing for this slave; ≥2.
- ID_W, $clog2(CHANNEL_NUM): width of owner_id.

- HCLK  in  1  bus clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- hreq  in  CHANNEL_NUM  per master: decoder selects this slave and master htrans≠IDLE.
- htrans_in  in  CHANNEL_NUM×2  per-master HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst_in  in  CHANNEL_NUM×3  per-master HBURST.
- hmastlock_in  in  CHANNEL_NUM  per-master HMASTLOCK; used only with the lock feature.
- hready_in  in  1  slave HREADYOUT; high = current data phase completes this cycle.
- addr_sel  out  CHANNEL_NUM  one-hot or zero address-phase mux select (registered).
- data_sel  out  CHANNEL_NUM  one-hot or zero data-phase mux select (registered).
- owner_id  out  ID_W  binary index of addr_sel owner; 0 when addr_sel=0.

## Operation
- States: IDLE (no owner, addr_sel=0) and OWN (one owner).
- Rearbitration point (RP), evaluated only when hready_in=1:
  - in IDLE, always;
  - in OWN, when any of the following holds:
    - owner hreq=0;
    - owner htrans=IDLE;
    - owner htrans=NONSEQ with hburst=SINGLE;
    - owner htrans=SEQ with beat counter = 1 (last beat).
- Beat counter:
  - loaded on an accepted owner NONSEQ with length − 1: INCR4/WRAP4→3, INCR8/WRAP8→7, INCR16/WRAP16→15;
  - decremented on each accepted SEQ;
  - BUSY does not decrement;
  - INCR (undefined length) loads 0 and never ends the burst by count.
- At an RP, the winner is the first requester with hreq=1, scanning circularly from (last granted index + 1). The pointer updates to the winner. No requester → IDLE, addr_sel=0, pointer unchanged.
- An owner that is still requesting at an RP competes normally. It keeps the grant only if no other master is ahead of it in round-robin order.
- data_sel: when hready_in=1, loads addr_sel if the owner htrans ∈ {NONSEQ, SEQ}, otherwise 0. Holds while hready_in=0.
- Wait states (hready_in=0) freeze addr_sel, data_sel, beat counter and pointer.

## Timing
- Reset values: addr_sel=0, data_sel=0, owner_id=0, state=IDLE, beat counter=0, pointer set so channel 0 wins first.
- Grant latency: request at cycle N with hready_in=1 in IDLE → addr_sel valid at N+1.
- data_sel follows addr_sel by one accepted transfer (1 cycle with zero wait states).
- Simultaneous requests resolve in the same cycle. Exactly one bit is set in addr_sel.
- Reset asserted mid-burst: all outputs go to 0 immediately (asynchronously). The burst is abandoned and not resumed.
- Handover: the old owner's last data phase uses data_sel while the new owner's address phase uses addr_sel in the same cycle.

## Configuration
- AHB_ARB_LOCK_EN defined: while the owner's hmastlock_in=1, every RP is suppressed except owner hreq=0. Locked sequences are never interrupted.
- AHB_ARB_LOCK_EN undefined: hmastlock_in is ignored, and RPs follow the rules above only.

## Test plan
- Reset then hreq=2'b01, NONSEQ SINGLE, hready_in=1 → addr_sel=01 next cycle, data_sel=01 the cycle after, owner_id=0.
- hreq=2'b11 in IDLE from reset → M0 first. After its SINGLE completes, M1 is granted next. Grants alternate 01,10,01 while both request.
- M0 INCR4 (NONSEQ + 3 SEQ) with M1 requesting throughout → addr_sel stays 01 for 4 accepted beats, then switches to 10.
- INCR4 with hready_in=0 for 3 cycles on beat 2 → addr_sel, data_sel and counter frozen; burst still ends after exactly 4 accepted beats.
- Lock enabled: M0 hmastlock=1, three SINGLEs, M1 requesting → M0 holds all three. Without the macro, M1 is granted after the first.
- HRESETn low during beat 3 of INCR8 → addr_sel=data_sel=0 asynchronously. After release with M1 requesting → M0-priority pointer restored and M1 granted next cycle.
